// File: rtl/data_mem_responder.sv
// Word-organised data memory answering the load/store port over a valid/ready
// request/response handshake, one transaction in flight, fixed access latency.
module data_mem_responder #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [3:0]            req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_we;
    logic [31:0]           r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [3:0]            r_be;
    logic [3:0]            r_cnt;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_fault;
    logic                  w_commit;
    logic [ADDR_WIDTH-1:0] w_idx;

    assign w_fault  = (r_addr[1:0] != 2'b00) || (r_addr[31:ADDR_WIDTH+2] != '0);
    assign w_idx    = r_addr[ADDR_WIDTH+1:2];
    assign w_commit = (r_state == BUSY) && (r_cnt == '0);

    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_next = BUSY;
            end
            BUSY: begin
                if (r_cnt == '0) w_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && req_valid) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_be    <= req_be;
                r_cnt   <= 4'(LATENCY - 1);
            end else if (r_state == BUSY && r_cnt != '0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            // Response data is produced at commit and held until the next commit.
            if (w_commit) begin
                if (w_fault) begin
                    r_rdata <= '0;
                    r_err   <= 1'b1;
                end else if (r_we) begin
                    r_rdata <= '0;
                    r_err   <= 1'b0;
                end else begin
                    r_rdata <= r_mem[w_idx];
                    r_err   <= 1'b0;
                end
            end
        end
    end

    // Array is not reset; a reset before commit leaves r_state out of BUSY, so no write.
    always_ff @(posedge clk) begin
        if (w_commit && !w_fault && r_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (r_be[i]) r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
            end
        end
    end

endmodule
